// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// uart_arb_pkg : shared state encoding, byte width and width helper
// Rev 1.0
// ============================================================================
package uart_arb_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin selector, search starts at ptr+1
// Rev 1.0
// ============================================================================
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  typedef logic [IW:0] cand_t;

  // One extra bit so ptr+k never overflows before the modulo-N fold.
  cand_t cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, ptr} + cand_t'(k);
      if (cand >= cand_t'(N)) cand = cand - cand_t'(N);
      if (!any && valid[cand[IW-1:0]]) begin
        any = 1'b1;
        idx = cand[IW-1:0];
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : round-robin sharing of one UART transmitter among N_REQ
// byte producers. Define UART_ARB_LOCK_EN to hold the grant for a message.
// Rev 1.0
// ============================================================================
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]       tx_data,
  output logic                         tx_start,
  input  logic                         tx_done,
  output logic [clog2(N_REQ)-1:0]      grant_id,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int GW  = clog2(N_REQ);
  localparam int WDW = clog2(TIMEOUT_CYCLES);

  typedef logic [GW-1:0]    idx_t;
  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [WDW:0]     wd_ext_t;

  localparam wd_ext_t WD_LIMIT = wd_ext_t'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q, state_d;
  idx_t                   ptr_q, ptr_d;
  idx_t                   grant_id_q, grant_id_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   busy_q, busy_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [WDW-1:0]         wd_q, wd_d;
  wd_ext_t                wd_next;

  req_vec_t pick_valid, pick_grant;
  idx_t     pick_idx;
  logic     pick_any;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;
  idx_t lock_id_q, lock_id_d;

  // While locked only the owner of the open message may compete.
  always_comb begin
    pick_valid = req_valid;
    if (lock_q) pick_valid = req_valid & (req_vec_t'(1) << lock_id_q);
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign pick_valid  = req_valid;
`endif

  rr_pick #(
    .N  (N_REQ),
    .IW (GW)
  ) u_rr_pick (
    .valid (pick_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready = (state_q == IDLE && !rst) ? pick_grant : '0;
  assign wd_next   = {1'b0, wd_q} + wd_ext_t'(1);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;
    wd_d          = wd_q;
`ifdef UART_ARB_LOCK_EN
    lock_d        = lock_q;
    lock_id_d     = lock_id_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = LAUNCH;
          ptr_d      = pick_idx;
          grant_id_d = pick_idx;
          tx_data_d  = req_data[pick_idx*UART_BYTE_W +: UART_BYTE_W];
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
`ifdef UART_ARB_LOCK_EN
          lock_d     = !req_last[pick_idx];
          lock_id_d  = pick_idx;
`endif
        end
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        wd_d = wd_next[WDW-1:0];
        // A completion in the same cycle as the limit takes priority.
        if (tx_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (wd_next >= WD_LIMIT) begin
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
`ifdef UART_ARB_LOCK_EN
          lock_d        = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= idx_t'(N_REQ - 1);
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      wd_q          <= wd_d;
    end
  end

`ifdef UART_ARB_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`endif

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : directed self-checking bench for uart_tx_arbiter
// Rev 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 50;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_start, tx_done;
  logic [1:0]     grant_id;
  logic           busy, timeout_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_data  = '0;
    req_last  = '1;
    tx_done   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req_valid = 3'b101;
    tick(); #1;
    total++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl busy/start/terr=%b%b%b want 000", busy, tx_start, timeout_err);
    end
    total++;
    if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
      bad++; $display("FAIL reset_data tx_data=%h grant_id=%0d want 00/0", tx_data, grant_id);
    end
    total++;
    if (req_ready !== 3'b000) begin
      bad++; $display("FAIL reset_ready req_ready=%b want 000", req_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 3'b001) begin
      bad++; $display("FAIL reset_prio req_ready=%b want 001", req_ready);
    end
    req_valid = '0;
    tick(); #1;
    total++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      bad++; $display("FAIL withdraw busy=%b start=%b want 0 0", busy, tx_start);
    end
    idle_inputs();
  endtask

  task automatic test_single();
    tick();
    req_valid = 3'b010;
    req_data  = 24'h00A500;
    #1;
    total++;
    if (req_ready !== 3'b010) begin
      bad++; $display("FAIL single_ready req_ready=%b want 010", req_ready);
    end
    tick();
    req_valid = 3'b111;
    tx_done   = 1'b1;
    #1;
    total++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
      bad++; $display("FAIL single_launch start=%b tx_data=%h want 1/a5", tx_start, tx_data);
    end
    total++;
    if (grant_id !== 2'd1 || busy !== 1'b1 || req_ready !== 3'b000) begin
      bad++; $display("FAIL single_state gid=%0d busy=%b ready=%b want 1/1/000", grant_id, busy, req_ready);
    end
    tick();
    req_valid = '0;
    tx_done   = 1'b0;
    #1;
    total++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL single_wait start=%b busy=%b want 0/1", tx_start, busy);
    end
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || grant_id !== 2'd1 || tx_data !== 8'hA5 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL single_done busy=%b gid=%0d data=%h terr=%b want 0/1/a5/0", busy, grant_id, tx_data, timeout_err);
    end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    int starts;
    int done_at;
    int start_cyc[6];
    int ids[6];
    logic [7:0] dat[6];
    logic [7:0] exp8;
    starts  = 0;
    done_at = -1;
    do_reset();
    req_valid = 3'b111;
    req_data  = 24'h121110;
    for (int i = 0; i < 150 && starts < 6; i++) begin
      tick();
      tx_done = (cyc == done_at);
      #1;
      if (tx_start === 1'b1) begin
        start_cyc[starts] = cyc;
        ids[starts]       = int'(grant_id);
        dat[starts]       = tx_data;
        starts++;
        done_at = cyc + 10;
      end
    end
    total++;
    if (starts != 6) begin
      bad++; $display("FAIL rr_starts got=%0d want 6", starts);
    end
    for (int k = 0; k < starts; k++) begin
      exp8 = 8'(16 + (k % 3));
      total++;
      if (ids[k] !== (k % 3) || dat[k] !== exp8) begin
        bad++; $display("FAIL rr_grant[%0d] id=%0d data=%h want %0d/%h", k, ids[k], dat[k], k % 3, exp8);
      end
      if (k > 0) begin
        total++;
        if (start_cyc[k] - start_cyc[k-1] !== 12) begin
          bad++; $display("FAIL rr_spacing[%0d] got=%0d want 12", k, start_cyc[k] - start_cyc[k-1]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int s;
    int hit;
    logic hit_busy;
    hit = -1;
    hit_busy = 1'bx;
    do_reset();
    tick();
    req_valid = 3'b001;
    req_data  = 24'h00005A;
    #1;
    tick();
    req_valid = '0;
    #1;
    s = cyc;
    total++;
    if (tx_start !== 1'b1) begin
      bad++; $display("FAIL to_launch start=%b want 1", tx_start);
    end
    for (int i = 0; i < 100 && hit < 0; i++) begin
      tick(); #1;
      if (timeout_err === 1'b1) begin
        hit      = cyc;
        hit_busy = busy;
      end
    end
    total++;
    if (hit - s !== TO) begin
      bad++; $display("FAIL to_latency got=%0d want %0d", hit - s, TO);
    end
    total++;
    if (hit_busy !== 1'b0) begin
      bad++; $display("FAIL to_busy busy=%b want 0", hit_busy);
    end
    tick(); #1;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++; $display("FAIL to_pulse terr=%b want 0", timeout_err);
    end
    req_valid = 3'b101;
    #1;
    total++;
    if (req_ready !== 3'b100) begin
      bad++; $display("FAIL to_regrant req_ready=%b want 100", req_ready);
    end
    idle_inputs();
  endtask

  task automatic test_coincide();
    int s;
    logic err_seen;
    err_seen = 1'b0;
    do_reset();
    tick();
    req_valid = 3'b100;
    req_data  = 24'hC30000;
    tick();
    req_valid = '0;
    #1;
    s = cyc;
    while (cyc < s + TO - 1) begin
      tick(); #1;
      if (timeout_err === 1'b1) err_seen = 1'b1;
    end
    tx_done = 1'b1;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL co_busy_limit busy=%b want 1", busy);
    end
    tick();
    tx_done = 1'b0;
    #1;
    total++;
    if (timeout_err !== 1'b0 || err_seen !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL co_no_err terr=%b early=%b busy=%b want 0/0/0", timeout_err, err_seen, busy);
    end
    total++;
    if (grant_id !== 2'd2 || tx_data !== 8'hC3) begin
      bad++; $display("FAIL co_hold gid=%0d data=%h want 2/c3", grant_id, tx_data);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    tick();
    req_valid = 3'b010;
    req_data  = 24'h007700;
    tick();
    req_valid = '0;
    repeat (3) tick();
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL mid_busy busy=%b want 1", busy);
    end
    #2;
    rst       = 1'b1;
    req_valid = 3'b101;
    req_data  = 24'h440011;
    #1;
    total++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || timeout_err !== 1'b0 || tx_data !== 8'h00 ||
        grant_id !== 2'd0 || req_ready !== 3'b000) begin
      bad++; $display("FAIL mid_async busy=%b start=%b terr=%b data=%h gid=%0d ready=%b want all 0",
                      busy, tx_start, timeout_err, tx_data, grant_id, req_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 3'b001) begin
      bad++; $display("FAIL mid_tie req_ready=%b want 001", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    total++;
    if (tx_start !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'h11) begin
      bad++; $display("FAIL mid_launch start=%b gid=%0d data=%h want 1/0/11", tx_start, grant_id, tx_data);
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    logic [7:0] q0[$];
    logic [7:0] q2[$];
    logic       l2[$];
    int         st_ids[$];
    logic [7:0] st_dat[$];
    int         exp_ids[5];
    logic [7:0] exp_dat[5];
    int         done_at;
    q0 = '{8'hC0, 8'hC1};
    q2 = '{8'hE0, 8'hE1, 8'hE2};
    l2 = '{1'b0, 1'b0, 1'b1};
`ifdef UART_ARB_LOCK_EN
    exp_ids = '{0, 2, 2, 2, 0};
    exp_dat = '{8'hC0, 8'hE0, 8'hE1, 8'hE2, 8'hC1};
`else
    exp_ids = '{0, 2, 0, 2, 2};
    exp_dat = '{8'hC0, 8'hE0, 8'hC1, 8'hE1, 8'hE2};
`endif
    done_at = -1;
    do_reset();
    for (int i = 0; i < 200 && st_dat.size() < 5; i++) begin
      tick();
      tx_done   = (cyc == done_at);
      req_valid = {q2.size() > 0, 1'b0, q0.size() > 0};
      req_data  = {(q2.size() > 0) ? q2[0] : 8'h00, 8'h00, (q0.size() > 0) ? q0[0] : 8'h00};
      req_last  = {(l2.size() > 0) ? l2[0] : 1'b1, 1'b1, 1'b1};
      #1;
      if (tx_start === 1'b1) begin
        st_ids.push_back(int'(grant_id));
        st_dat.push_back(tx_data);
        done_at = cyc + 4;
      end
      if ((req_valid & req_ready) == 3'b001) begin
        void'(q0.pop_front());
      end else if ((req_valid & req_ready) == 3'b100) begin
        void'(q2.pop_front());
        void'(l2.pop_front());
      end
    end
    total++;
    if (st_dat.size() != 5) begin
      bad++; $display("FAIL lock_count got=%0d want 5", st_dat.size());
    end
    for (int k = 0; k < st_dat.size() && k < 5; k++) begin
      total++;
      if (st_ids[k] !== exp_ids[k] || st_dat[k] !== exp_dat[k]) begin
        bad++; $display("FAIL lock_order[%0d] id=%0d data=%h want %0d/%h", k, st_ids[k], st_dat[k], exp_ids[k], exp_dat[k]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_coincide();
    test_reset_mid();
    test_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded at cycle %0d", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule
`default_nettype wire
